// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC and fetch stage with IF/ID register, stall, redirect, wrap; optional halt detect via IF_HALT_DETECT_EN
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_LAST  = 16'd8192
`ifdef IF_HALT_DETECT_EN
  ,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] D_Instruction,
  output logic [15:0] A_InstrAddress,
  output logic        C_IMRead,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic [15:0] if_id_pc_plus1,
  output logic        if_id_valid,
  output logic        fetch_fault,
`ifdef IF_HALT_DETECT_EN
  output logic        halted,
`endif
  output logic [15:0] fetch_count
);
`ifdef IF_HALT_DETECT_EN
  typedef enum logic [1:0] {BOOT, RUN, FAULT, HALT} state_t;
`else
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
`endif
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, instr_q, instr_d, ipc_q, ipc_d, ipc1_q, ipc1_d, count_q, count_d;
  logic        valid_q, valid_d, fault_q, fault_d;
  logic [15:0] next_pc;
  logic        redir_ok;
  assign next_pc        = (pc_q == PC_LAST) ? 16'h0000 : pc_q + 16'd1;
  assign redir_ok       = redirect_valid && (redirect_target <= PC_LAST);
  assign A_InstrAddress = pc_q;
  assign C_IMRead       = (state_q == RUN);
  assign if_id_instr    = instr_q;
  assign if_id_pc       = ipc_q;
  assign if_id_pc_plus1 = ipc1_q;
  assign if_id_valid    = valid_q;
  assign fetch_fault    = fault_q;
  assign fetch_count    = count_q;
`ifdef IF_HALT_DETECT_EN
  assign halted         = (state_q == HALT);
`endif
  // next-state: redirect beats stall, bad redirect faults, otherwise capture and advance
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc1_d  = ipc1_q;
    valid_d = valid_q;
    fault_d = fault_q;
    count_d = count_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          pc_d    = redir_ok ? redirect_target : pc_q;
          fault_d = fault_q | ~redir_ok;
          state_d = redir_ok ? RUN : FAULT;
        end else if (!stall) begin
          instr_d = D_Instruction;
          ipc_d   = pc_q;
          ipc1_d  = next_pc;
          valid_d = 1'b1;
          pc_d    = next_pc;
          count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
`ifdef IF_HALT_DETECT_EN
          if (D_Instruction == HALT_WORD) begin
            pc_d    = pc_q;
            state_d = HALT;
          end
`endif
        end
      end
`ifdef IF_HALT_DETECT_EN
      HALT: begin
        valid_d = 1'b0;
        pc_d    = redir_ok ? redirect_target : pc_q;
        state_d = redir_ok ? RUN : HALT;
      end
`endif
      FAULT: valid_d = 1'b0;
      default: state_d = BOOT;
    endcase
  end
  // state and pipeline registers, cleared immediately by async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
      ipc_q   <= 16'h0000;
      ipc1_q  <= 16'h0000;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc1_q  <= ipc1_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] D_Instruction;
  logic [15:0] A_InstrAddress;
  logic        C_IMRead;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_target = 16'h0000;
  logic [15:0] if_id_instr, if_id_pc, if_id_pc_plus1, fetch_count;
  logic        if_id_valid, fetch_fault;
`ifdef IF_HALT_DETECT_EN
  logic        halted;
`endif
  int checks = 0;
  int errors = 0;
  instruction_fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .D_Instruction(D_Instruction),
    .A_InstrAddress(A_InstrAddress),
    .C_IMRead(C_IMRead),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc),
    .if_id_pc_plus1(if_id_pc_plus1),
    .if_id_valid(if_id_valid),
    .fetch_fault(fetch_fault),
`ifdef IF_HALT_DETECT_EN
    .halted(halted),
`endif
    .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] mem(input logic [15:0] a);
    case (a)
      16'd0: mem = 16'h1111;
      16'd1: mem = 16'h2222;
      16'd2: mem = 16'h3333;
      16'd3: mem = 16'h4444;
      16'd5: mem = 16'hFFFF;
      default: mem = a + 16'h5000;
    endcase
  endfunction
  assign D_Instruction = mem(A_InstrAddress);
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic redirect(input logic [15:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    step();
    redirect_valid  = 1'b0;
  endtask
  initial begin
    step();
    step();
    check("rst_addr", A_InstrAddress, 16'h0000);
    check("rst_read", C_IMRead, 0);
    check("rst_instr", if_id_instr, 16'h0000);
    check("rst_pc", if_id_pc, 16'h0000);
    check("rst_pc1", if_id_pc_plus1, 16'h0000);
    check("rst_valid", if_id_valid, 0);
    check("rst_fault", fetch_fault, 0);
    check("rst_count", fetch_count, 16'h0000);
`ifdef IF_HALT_DETECT_EN
    check("rst_halted", halted, 0);
`endif
    rst = 1'b0;
    check("boot_read", C_IMRead, 0);
    step();
    check("run_read", C_IMRead, 1);
    check("run_valid0", if_id_valid, 0);
    check("run_addr0", A_InstrAddress, 16'h0000);
    step();
    check("cap0_instr", if_id_instr, 16'h1111);
    check("cap0_pc", if_id_pc, 16'h0000);
    check("cap0_pc1", if_id_pc_plus1, 16'h0001);
    check("cap0_valid", if_id_valid, 1);
    check("cap0_count", fetch_count, 16'd1);
    step();
    check("cap1_instr", if_id_instr, 16'h2222);
    check("cap1_addr", A_InstrAddress, 16'h0002);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", A_InstrAddress, 16'h0002);
      check("stall_instr", if_id_instr, 16'h2222);
      check("stall_count", fetch_count, 16'd2);
    end
    stall = 1'b0;
    step();
    check("cap2_instr", if_id_instr, 16'h3333);
    check("cap2_pc", if_id_pc, 16'h0002);
    step();
    check("cap3_instr", if_id_instr, 16'h4444);
    check("cap3_pc", if_id_pc, 16'h0003);
    check("cap3_count", fetch_count, 16'd4);
    stall = 1'b1;
    redirect(16'h0100);
    stall = 1'b0;
    check("rdst_valid", if_id_valid, 0);
    check("rdst_addr", A_InstrAddress, 16'h0100);
    check("rdst_count", fetch_count, 16'd4);
    step();
    check("rdcap_pc", if_id_pc, 16'h0100);
    check("rdcap_instr", if_id_instr, 16'h5100);
    check("rdcap_pc1", if_id_pc_plus1, 16'h0101);
    check("rdcap_valid", if_id_valid, 1);
    redirect(16'h1FFF);
    check("wr_addr", A_InstrAddress, 16'h1FFF);
    step();
    check("wr_pc_a", if_id_pc, 16'h1FFF);
    check("wr_addr_last", A_InstrAddress, 16'h2000);
    step();
    check("wr_pc_last", if_id_pc, 16'h2000);
    check("wr_pc1_last", if_id_pc_plus1, 16'h0000);
    check("wr_instr_last", if_id_instr, 16'h7000);
    check("wr_addr_zero", A_InstrAddress, 16'h0000);
    step();
    check("wr_pc_zero", if_id_pc, 16'h0000);
    check("wr_instr_zero", if_id_instr, 16'h1111);
    check("wr_count", fetch_count, 16'd8);
    redirect(16'h3000);
    check("flt_fault", fetch_fault, 1);
    check("flt_read", C_IMRead, 0);
    check("flt_valid", if_id_valid, 0);
    check("flt_addr", A_InstrAddress, 16'h0001);
    redirect(16'h0010);
    step();
    check("flt_sticky", fetch_fault, 1);
    check("flt_hold_addr", A_InstrAddress, 16'h0001);
    check("flt_hold_read", C_IMRead, 0);
    check("flt_hold_valid", if_id_valid, 0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_fault", fetch_fault, 0);
    check("arst_count", fetch_count, 16'h0000);
    check("arst_instr", if_id_instr, 16'h0000);
    check("arst_pc", if_id_pc, 16'h0000);
    check("arst_addr", A_InstrAddress, 16'h0000);
    step();
    rst = 1'b0;
    step();
    step();
    check("re_instr", if_id_instr, 16'h1111);
    redirect(16'h0005);
    check("h_addr", A_InstrAddress, 16'h0005);
    step();
    check("h_instr", if_id_instr, 16'hFFFF);
    check("h_valid", if_id_valid, 1);
    check("h_pc", if_id_pc, 16'h0005);
`ifdef IF_HALT_DETECT_EN
    check("h_halted", halted, 1);
    check("h_read", C_IMRead, 0);
    check("h_addr_hold", A_InstrAddress, 16'h0005);
    stall = 1'b0;
    step();
    check("h_valid_drop", if_id_valid, 0);
    check("h_addr_frozen", A_InstrAddress, 16'h0005);
    check("h_halted2", halted, 1);
    redirect(16'h0000);
    check("h_resume_halted", halted, 0);
    check("h_resume_addr", A_InstrAddress, 16'h0000);
    check("h_resume_read", C_IMRead, 1);
    step();
    check("h_resume_instr", if_id_instr, 16'h1111);
    check("h_resume_valid", if_id_valid, 1);
`else
    check("nh_addr", A_InstrAddress, 16'h0006);
    step();
    check("nh_instr", if_id_instr, 16'h5006);
    check("nh_valid", if_id_valid, 1);
    check("nh_read", C_IMRead, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
